// File: rtl/index_decoder_scoreboard_pkg.sv
// Shared types for the index decoder scoreboard (default 16-slot configuration).
// Optional occupancy counter is enabled by defining INDEX_DECODER_SCOREBOARD_COUNT_EN.
package index_decoder_scoreboard_pkg;

    localparam int NUM_WIRE_DEF = 16;
    localparam int IDX_W_DEF    = $clog2(NUM_WIRE_DEF);

    typedef logic [NUM_WIRE_DEF-1:0] mask_t;
    typedef logic [IDX_W_DEF-1:0]    index_t;

endpackage

// File: rtl/index_decoder_scoreboard_if.sv
// Request/status bundle of the scoreboard; count_o exists only with INDEX_DECODER_SCOREBOARD_COUNT_EN.
interface index_decoder_scoreboard_if #(
    parameter int NUM_WIRE = 16
);
    localparam int IDX_W = $clog2(NUM_WIRE);

    logic                flush_i;
    logic                set_valid_i;
    logic [IDX_W-1:0]    set_index_i;
    logic                clear_valid_i;
    logic [IDX_W-1:0]    clear_index_i;
    logic [NUM_WIRE-1:0] wire_o;
    logic                empty_o;
    logic                full_o;
    logic                error_o;
`ifdef INDEX_DECODER_SCOREBOARD_COUNT_EN
    logic [IDX_W:0]      count_o;
`endif

    modport master (
        output flush_i, set_valid_i, set_index_i, clear_valid_i, clear_index_i,
`ifdef INDEX_DECODER_SCOREBOARD_COUNT_EN
        input  count_o,
`endif
        input  wire_o, empty_o, full_o, error_o
    );

    modport slave (
        input  flush_i, set_valid_i, set_index_i, clear_valid_i, clear_index_i,
`ifdef INDEX_DECODER_SCOREBOARD_COUNT_EN
        output count_o,
`endif
        output wire_o, empty_o, full_o, error_o
    );

endinterface

// File: rtl/index_decoder_scoreboard_onehot_decoder.sv
// Combinational index-to-one-hot decoder; flags indices beyond the tracked range.
module onehot_decoder #(
    parameter int NUM_WIRE = 16
) (
    input  logic [$clog2(NUM_WIRE)-1:0] index_i,
    input  logic                        valid_i,
    output logic [NUM_WIRE-1:0]         onehot_o,
    output logic                        out_of_range_o
);
    localparam int IDX_W = $clog2(NUM_WIRE);

    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NUM_WIRE; i++) begin
            onehot_o[i] = valid_i && (index_i == IDX_W'(i));
        end
    end

    // Widened by one bit so NUM_WIRE itself is representable when it is a power of two.
    assign out_of_range_o = valid_i && ({1'b0, index_i} >= (IDX_W+1)'(NUM_WIRE));

endmodule

// File: rtl/index_decoder_scoreboard.sv
// Occupancy scoreboard: index-addressed set/clear into a registered one-hot vector with sticky misuse flag.
// Define INDEX_DECODER_SCOREBOARD_COUNT_EN to add the incremental popcount output count_o.
module index_decoder_scoreboard
    import index_decoder_scoreboard_pkg::*;
#(
    parameter int NUM_WIRE = NUM_WIRE_DEF
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    index_decoder_scoreboard_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_WIRE);

    logic [NUM_WIRE-1:0] set_mask, clr_mask;
    logic                set_oor, clr_oor;
    logic [NUM_WIRE-1:0] wire_q, wire_d;
    logic                empty_q, empty_d;
    logic                full_q, full_d;
    logic                error_q, error_d;
    logic                set_hit, clr_hit, same_idx, set_was, clr_was, misuse;

    onehot_decoder #(.NUM_WIRE(NUM_WIRE)) set_dec (
        .index_i        (bus.set_index_i),
        .valid_i        (bus.set_valid_i),
        .onehot_o       (set_mask),
        .out_of_range_o (set_oor)
    );

    onehot_decoder #(.NUM_WIRE(NUM_WIRE)) clr_dec (
        .index_i        (bus.clear_index_i),
        .valid_i        (bus.clear_valid_i),
        .onehot_o       (clr_mask),
        .out_of_range_o (clr_oor)
    );

    assign set_hit  = |set_mask;
    assign clr_hit  = |clr_mask;
    assign same_idx = set_hit && clr_hit && (bus.set_index_i == bus.clear_index_i);
    assign set_was  = |(set_mask & wire_q);
    assign clr_was  = |(clr_mask & wire_q);

    // A same-index set+clear on a 0 bit still fails the clear check, since set wins only for the update.
    assign misuse = (set_hit && set_was && !same_idx) || (clr_hit && !clr_was) || set_oor || clr_oor;

    always_comb begin
        wire_d  = wire_q;
        error_d = error_q;
        if (bus.flush_i) begin
            wire_d  = '0;
            error_d = 1'b0;
        end else begin
            wire_d  = (wire_q & ~clr_mask) | set_mask;
            error_d = error_q | misuse;
        end
        empty_d = (wire_d == '0);
        full_d  = &wire_d;
    end

`ifdef INDEX_DECODER_SCOREBOARD_COUNT_EN
    logic [IDX_W:0] count_q, count_d;
    logic           cnt_inc, cnt_dec;

    // The same-index set+clear on a 1 bit leaves it set, so neither side moves the count.
    assign cnt_inc = set_hit && !set_was;
    assign cnt_dec = clr_hit && clr_was && !same_idx;

    always_comb begin
        count_d = count_q;
        if (bus.flush_i) begin
            count_d = '0;
        end else begin
            count_d = count_q + (IDX_W+1)'(cnt_inc) - (IDX_W+1)'(cnt_dec);
        end
    end

    assign bus.count_o = count_q;
`endif

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wire_q  <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef INDEX_DECODER_SCOREBOARD_COUNT_EN
            count_q <= '0;
`endif
        end else begin
            wire_q  <= wire_d;
            empty_q <= empty_d;
            full_q  <= full_d;
            error_q <= error_d;
`ifdef INDEX_DECODER_SCOREBOARD_COUNT_EN
            count_q <= count_d;
`endif
        end
    end

    assign bus.wire_o  = wire_q;
    assign bus.empty_o = empty_q;
    assign bus.full_o  = full_q;
    assign bus.error_o = error_q;

endmodule
